// File: rtl/axi_txn_sequencer.sv
// Drives INIT_AXI_TXN of an AXI master test engine for a programmable number of runs and keeps pass/fail statistics.
// Optional watchdog on the completion wait is compiled in with `define SEQ_TIMEOUT_EN.
module axi_txn_sequencer #(
  parameter int CNT_W          = 16,
  parameter int GAP_W          = 8,
  parameter int INIT_PULSE_W   = 2,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic             ACLK,
  input  logic             ARESET,
  input  logic             START,
  input  logic             ABORT,
  input  logic [CNT_W-1:0] RUN_COUNT,
  input  logic [GAP_W-1:0] GAP_CYCLES,
  input  logic             STOP_ON_ERR,
  output logic             TXN_INIT,
  input  logic             TXN_DONE,
  input  logic             TXN_ERROR,
  output logic             BUSY,
  output logic             SEQ_DONE,
  output logic [CNT_W-1:0] RUNS_DONE,
  output logic [CNT_W-1:0] PASS_CNT,
  output logic [CNT_W-1:0] FAIL_CNT,
  output logic             ERROR_STICKY,
  output logic             TIMEOUT
);

  localparam int PW = (INIT_PULSE_W > 1) ? $clog2(INIT_PULSE_W) : 1;

  typedef enum logic [1:0] {IDLE, INIT, WAIT, GAP} state_t;

  state_t           state_reg;
  logic [PW-1:0]    pulse_cnt_reg;
  logic [GAP_W-1:0] gap_cnt_reg;
  logic [GAP_W-1:0] gap_reg;
  logic [CNT_W-1:0] run_count_reg;
  logic             stop_on_err_reg;
  logic             abort_flag_reg;
  logic             done_q_reg;
  logic             done_edge;
  logic             last_run;
  logic             end_seq;

`ifdef SEQ_TIMEOUT_EN
  localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [WD_W-1:0] wd_cnt_reg;
`else
  assign TIMEOUT = 1'b0;
`endif

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // A done level left over from the previous run never looks like a fresh edge.
  assign done_edge = TXN_DONE & ~done_q_reg;
  assign last_run  = (run_count_reg != '0) &&
                     (({1'b0, RUNS_DONE} + (CNT_W+1)'(1)) == {1'b0, run_count_reg});
  assign end_seq   = last_run | abort_flag_reg | ABORT | (stop_on_err_reg & TXN_ERROR);

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_reg       <= IDLE;
      pulse_cnt_reg   <= '0;
      gap_cnt_reg     <= '0;
      gap_reg         <= '0;
      run_count_reg   <= '0;
      stop_on_err_reg <= 1'b0;
      abort_flag_reg  <= 1'b0;
      done_q_reg      <= 1'b0;
      TXN_INIT        <= 1'b0;
      BUSY            <= 1'b0;
      SEQ_DONE        <= 1'b0;
      RUNS_DONE       <= '0;
      PASS_CNT        <= '0;
      FAIL_CNT        <= '0;
      ERROR_STICKY    <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
      wd_cnt_reg      <= '0;
      TIMEOUT         <= 1'b0;
`endif
    end else begin
      done_q_reg <= TXN_DONE;
      SEQ_DONE   <= 1'b0;
      if (BUSY && ABORT) abort_flag_reg <= 1'b1;

      unique case (state_reg)
        IDLE: begin
          if (START) begin
            run_count_reg   <= RUN_COUNT;
            gap_reg         <= GAP_CYCLES;
            stop_on_err_reg <= STOP_ON_ERR;
            RUNS_DONE       <= '0;
            PASS_CNT        <= '0;
            FAIL_CNT        <= '0;
            ERROR_STICKY    <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
            TIMEOUT         <= 1'b0;
`endif
            BUSY            <= 1'b1;
            TXN_INIT        <= 1'b1;
            pulse_cnt_reg   <= '0;
            state_reg       <= INIT;
          end
        end

        INIT: begin
          if (pulse_cnt_reg == PW'(INIT_PULSE_W - 1)) begin
            TXN_INIT  <= 1'b0;
            state_reg <= WAIT;
`ifdef SEQ_TIMEOUT_EN
            wd_cnt_reg <= '0;
`endif
          end else begin
            pulse_cnt_reg <= pulse_cnt_reg + PW'(1);
          end
        end

        WAIT: begin
          if (done_edge) begin
            RUNS_DONE <= sat_inc(RUNS_DONE);
            if (TXN_ERROR) begin
              FAIL_CNT     <= sat_inc(FAIL_CNT);
              ERROR_STICKY <= 1'b1;
            end else begin
              PASS_CNT <= sat_inc(PASS_CNT);
            end
            if (end_seq) begin
              BUSY           <= 1'b0;
              SEQ_DONE       <= 1'b1;
              abort_flag_reg <= 1'b0;
              state_reg      <= IDLE;
            end else if (gap_reg == '0) begin
              TXN_INIT      <= 1'b1;
              pulse_cnt_reg <= '0;
              state_reg     <= INIT;
            end else begin
              gap_cnt_reg <= '0;
              state_reg   <= GAP;
            end
          end
`ifdef SEQ_TIMEOUT_EN
          // A hung master is counted as a failed run and always ends the sequence.
          else if (wd_cnt_reg == WD_W'(TIMEOUT_CYCLES - 1)) begin
            RUNS_DONE      <= sat_inc(RUNS_DONE);
            FAIL_CNT       <= sat_inc(FAIL_CNT);
            ERROR_STICKY   <= 1'b1;
            TIMEOUT        <= 1'b1;
            BUSY           <= 1'b0;
            SEQ_DONE       <= 1'b1;
            abort_flag_reg <= 1'b0;
            state_reg      <= IDLE;
          end else begin
            wd_cnt_reg <= wd_cnt_reg + WD_W'(1);
          end
`endif
        end

        GAP: begin
          if (ABORT || abort_flag_reg) begin
            BUSY           <= 1'b0;
            SEQ_DONE       <= 1'b1;
            abort_flag_reg <= 1'b0;
            state_reg      <= IDLE;
          end else if (gap_cnt_reg == gap_reg - GAP_W'(1)) begin
            TXN_INIT      <= 1'b1;
            pulse_cnt_reg <= '0;
            state_reg     <= INIT;
          end else begin
            gap_cnt_reg <= gap_cnt_reg + GAP_W'(1);
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_txn_sequencer.sv
// Directed bench for axi_txn_sequencer with a behavioural AXI master model answering TXN_INIT.
module tb_axi_txn_sequencer;

  logic       ACLK = 1'b0;
  logic       ARESET = 1'b1;
  logic       START = 1'b0;
  logic       ABORT = 1'b0;
  logic [3:0] RUN_COUNT = '0;
  logic [7:0] GAP_CYCLES = '0;
  logic       STOP_ON_ERR = 1'b0;
  logic       TXN_INIT;
  logic       TXN_DONE = 1'b0;
  logic       TXN_ERROR = 1'b0;
  logic       BUSY, SEQ_DONE, ERROR_STICKY, TIMEOUT;
  logic [3:0] RUNS_DONE, PASS_CNT, FAIL_CNT;

  int total = 0;
  int bad = 0;

  axi_txn_sequencer #(.CNT_W(4), .GAP_W(8), .INIT_PULSE_W(2), .TIMEOUT_CYCLES(64)) dut (
    .ACLK(ACLK), .ARESET(ARESET), .START(START), .ABORT(ABORT),
    .RUN_COUNT(RUN_COUNT), .GAP_CYCLES(GAP_CYCLES), .STOP_ON_ERR(STOP_ON_ERR),
    .TXN_INIT(TXN_INIT), .TXN_DONE(TXN_DONE), .TXN_ERROR(TXN_ERROR),
    .BUSY(BUSY), .SEQ_DONE(SEQ_DONE), .RUNS_DONE(RUNS_DONE), .PASS_CNT(PASS_CNT),
    .FAIL_CNT(FAIL_CNT), .ERROR_STICKY(ERROR_STICKY), .TIMEOUT(TIMEOUT)
  );

  always #5 ACLK = ~ACLK;

  // Master model: done rises done_lat cycles after an init rise, old done level held stale_hold cycles.
  int      done_lat = 20;
  int      stale_hold = 0;
  bit      never_done = 1'b0;
  bit [31:0] err_mask = '0;
  int      cyc = 0;
  int      m_runs = 0;
  int      m_cnt = 0;
  bit      m_active = 1'b0;
  int      m_hold = 0;
  logic    init_q = 1'b0;
  int      hi_cnt = 0;
  int      w_min = 1000, w_max = 0;
  int      s_min = 1000, s_max = 0;
  int      done_cyc = 0;
  int      rise_cyc = 0;

  always @(posedge ACLK) begin
    cyc++;
    if (TXN_INIT) hi_cnt++;
    if (TXN_INIT && !init_q) begin
      if (m_runs > 0) begin
        if (cyc - done_cyc < s_min) s_min = cyc - done_cyc;
        if (cyc - done_cyc > s_max) s_max = cyc - done_cyc;
      end
      m_runs++;
      hi_cnt   = 1;
      rise_cyc = cyc;
      m_cnt    = 0;
      m_active = 1'b1;
      m_hold   = stale_hold;
      if (m_hold == 0) TXN_DONE <= 1'b0;
    end else begin
      if (m_hold > 0) begin
        m_hold--;
        if (m_hold == 0) TXN_DONE <= 1'b0;
      end
      if (m_active) begin
        m_cnt++;
        if (m_cnt == done_lat && !never_done) begin
          TXN_DONE  <= 1'b1;
          TXN_ERROR <= err_mask[m_runs];
          done_cyc  = cyc;
          m_active  = 1'b0;
        end
      end
    end
    if (!TXN_INIT && init_q) begin
      if (hi_cnt < w_min) w_min = hi_cnt;
      if (hi_cnt > w_max) w_max = hi_cnt;
    end
    init_q = TXN_INIT;
  end

  task automatic start_seq(input int rc, input int gap, input bit stop, input bit with_abort);
    m_runs = 0; m_active = 1'b0; m_hold = 0;
    w_min = 1000; w_max = 0; s_min = 1000; s_max = 0;
    @(negedge ACLK);
    RUN_COUNT = 4'(rc); GAP_CYCLES = 8'(gap); STOP_ON_ERR = stop;
    START = 1'b1; ABORT = with_abort;
    @(negedge ACLK);
    START = 1'b0; ABORT = 1'b0;
  endtask

  task automatic wait_seq_done(input int maxc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      if (SEQ_DONE) begin ok = 1'b1; break; end
      @(negedge ACLK);
    end
  endtask

  task automatic wait_runs(input int n, input int maxc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      if (m_runs >= n) begin ok = 1'b1; break; end
      @(negedge ACLK);
    end
  endtask

  task automatic pulse_abort();
    ABORT = 1'b1;
    @(negedge ACLK);
    ABORT = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge ACLK);
    total++;
    if ({TXN_INIT, BUSY, SEQ_DONE, ERROR_STICKY, TIMEOUT, RUNS_DONE, PASS_CNT, FAIL_CNT} !== 17'd0) begin
      bad++; $display("FAIL reset_outputs got=%h want=0",
        {TXN_INIT, BUSY, SEQ_DONE, ERROR_STICKY, TIMEOUT, RUNS_DONE, PASS_CNT, FAIL_CNT});
    end
    ARESET = 1'b0;
    repeat (2) @(negedge ACLK);
    total++;
    if ({BUSY, TXN_INIT} !== 2'b00) begin bad++; $display("FAIL reset_idle got=%b want=00", {BUSY, TXN_INIT}); end
    $display("reset: busy=%0b runs=%0d", BUSY, RUNS_DONE);
  endtask

  task automatic test_basic();
    bit ok;
    done_lat = 20; stale_hold = 0; err_mask = '0;
    start_seq(3, 4, 1'b0, 1'b0);
    total++;
    if ({BUSY, TXN_INIT} !== 2'b11) begin bad++; $display("FAIL basic_start got=%b want=11", {BUSY, TXN_INIT}); end
    wait_runs(2, 200, ok);
    START = 1'b1; RUN_COUNT = 4'd9;
    @(negedge ACLK);
    START = 1'b0;
    wait_seq_done(400, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL basic_seq_done got=timeout want=pulse"); end
    total++;
    if (BUSY !== 1'b0) begin bad++; $display("FAIL basic_busy got=%0b want=0", BUSY); end
    total++;
    if ({RUNS_DONE, PASS_CNT, FAIL_CNT, ERROR_STICKY} !== {4'd3, 4'd3, 4'd0, 1'b0}) begin
      bad++; $display("FAIL basic_counts got=%0d/%0d/%0d/%0b want=3/3/0/0", RUNS_DONE, PASS_CNT, FAIL_CNT, ERROR_STICKY);
    end
    total++;
    if (m_runs !== 3) begin bad++; $display("FAIL basic_inits got=%0d want=3", m_runs); end
    total++;
    if (w_min !== 2 || w_max !== 2) begin bad++; $display("FAIL basic_width got=%0d..%0d want=2", w_min, w_max); end
    // done raised at edge c -> edge detected at c+1 -> 4 gap cycles -> init seen at c+6
    total++;
    if (s_min !== 6 || s_max !== 6) begin bad++; $display("FAIL basic_spacing got=%0d..%0d want=6", s_min, s_max); end
    @(negedge ACLK);
    total++;
    if (SEQ_DONE !== 1'b0) begin bad++; $display("FAIL basic_pulse_len got=%0b want=0", SEQ_DONE); end
    $display("basic: runs=%0d pass=%0d fail=%0d inits=%0d", RUNS_DONE, PASS_CNT, FAIL_CNT, m_runs);
  endtask

  task automatic test_stop_on_err();
    bit ok;
    done_lat = 10; stale_hold = 0; err_mask = 32'h4;
    start_seq(5, 2, 1'b1, 1'b0);
    wait_seq_done(400, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL stop_seq_done got=timeout want=pulse"); end
    total++;
    if ({RUNS_DONE, PASS_CNT, FAIL_CNT, ERROR_STICKY} !== {4'd2, 4'd1, 4'd1, 1'b1}) begin
      bad++; $display("FAIL stop_counts got=%0d/%0d/%0d/%0b want=2/1/1/1", RUNS_DONE, PASS_CNT, FAIL_CNT, ERROR_STICKY);
    end
    total++;
    if (m_runs !== 2) begin bad++; $display("FAIL stop_inits got=%0d want=2", m_runs); end
    err_mask = '0;
    $display("stop_on_err: runs=%0d pass=%0d fail=%0d sticky=%0b", RUNS_DONE, PASS_CNT, FAIL_CNT, ERROR_STICKY);
  endtask

  task automatic test_stale_done();
    bit ok;
    done_lat = 10; stale_hold = 3;
    start_seq(2, 0, 1'b0, 1'b1);
    wait_runs(2, 200, ok);
    repeat (6) @(negedge ACLK);
    total++;
    if ({BUSY, RUNS_DONE} !== {1'b1, 4'd1}) begin
      bad++; $display("FAIL stale_no_false_done got=%0b/%0d want=1/1", BUSY, RUNS_DONE);
    end
    wait_seq_done(200, ok);
    total++;
    if (!ok || RUNS_DONE !== 4'd2 || PASS_CNT !== 4'd2 || m_runs !== 2) begin
      bad++; $display("FAIL stale_final got=ok%0b runs=%0d pass=%0d inits=%0d want=ok1 2/2/2", ok, RUNS_DONE, PASS_CNT, m_runs);
    end
    stale_hold = 0;
    $display("stale_done: runs=%0d pass=%0d inits=%0d", RUNS_DONE, PASS_CNT, m_runs);
  endtask

  task automatic test_abort_wait();
    bit ok;
    done_lat = 8;
    start_seq(0, 1, 1'b0, 1'b0);
    wait_runs(4, 400, ok);
    repeat (4) @(negedge ACLK);
    pulse_abort();
    wait_seq_done(200, ok);
    total++;
    if (!ok || RUNS_DONE !== 4'd4 || PASS_CNT !== 4'd4) begin
      bad++; $display("FAIL abort_counts got=ok%0b runs=%0d pass=%0d want=ok1 4/4", ok, RUNS_DONE, PASS_CNT);
    end
    repeat (30) @(negedge ACLK);
    total++;
    if (m_runs !== 4 || BUSY !== 1'b0) begin bad++; $display("FAIL abort_no_fifth got=%0d/%0b want=4/0", m_runs, BUSY); end
    $display("abort_wait: runs=%0d inits=%0d", RUNS_DONE, m_runs);
  endtask

  task automatic test_abort_gap();
    bit ok;
    ok = 1'b0;
    done_lat = 5;
    start_seq(0, 50, 1'b0, 1'b0);
    for (int i = 0; i < 100; i++) begin
      if (RUNS_DONE == 4'd1) begin ok = 1'b1; break; end
      @(negedge ACLK);
    end
    pulse_abort();
    total++;
    if (!ok || SEQ_DONE !== 1'b1 || BUSY !== 1'b0 || RUNS_DONE !== 4'd1) begin
      bad++; $display("FAIL abort_gap got=ok%0b done=%0b busy=%0b runs=%0d want=ok1 1/0/1", ok, SEQ_DONE, BUSY, RUNS_DONE);
    end
    $display("abort_gap: seq_done=%0b runs=%0d", SEQ_DONE, RUNS_DONE);
  endtask

  task automatic test_saturate();
    bit ok;
    done_lat = 3;
    start_seq(0, 0, 1'b0, 1'b0);
    wait_runs(17, 400, ok);
    pulse_abort();
    wait_seq_done(100, ok);
    total++;
    if (!ok || RUNS_DONE !== 4'hF || PASS_CNT !== 4'hF || FAIL_CNT !== 4'd0) begin
      bad++; $display("FAIL saturate got=ok%0b runs=%0d pass=%0d fail=%0d want=ok1 15/15/0", ok, RUNS_DONE, PASS_CNT, FAIL_CNT);
    end
    total++;
    if (m_runs !== 17) begin bad++; $display("FAIL saturate_inits got=%0d want=17", m_runs); end
    $display("saturate: runs=%0d pass=%0d inits=%0d", RUNS_DONE, PASS_CNT, m_runs);
  endtask

  task automatic test_async_reset();
    bit ok;
    ok = 1'b0;
    done_lat = 5;
    start_seq(5, 30, 1'b0, 1'b0);
    for (int i = 0; i < 200; i++) begin
      if (RUNS_DONE == 4'd2) begin ok = 1'b1; break; end
      @(negedge ACLK);
    end
    #2 ARESET = 1'b1;
    #1;
    total++;
    if (!ok || {TXN_INIT, BUSY, SEQ_DONE, RUNS_DONE, PASS_CNT} !== 11'd0) begin
      bad++; $display("FAIL async_reset got=ok%0b busy=%0b runs=%0d want=ok1 0/0", ok, BUSY, RUNS_DONE);
    end
    @(negedge ACLK);
    ARESET = 1'b0;
    start_seq(2, 0, 1'b0, 1'b0);
    wait_seq_done(200, ok);
    total++;
    if (!ok || RUNS_DONE !== 4'd2 || PASS_CNT !== 4'd2 || FAIL_CNT !== 4'd0) begin
      bad++; $display("FAIL reset_rerun got=ok%0b runs=%0d pass=%0d fail=%0d want=ok1 2/2/0", ok, RUNS_DONE, PASS_CNT, FAIL_CNT);
    end
    $display("async_reset: rerun runs=%0d pass=%0d", RUNS_DONE, PASS_CNT);
  endtask

  task automatic test_timeout();
    bit ok;
    never_done = 1'b1;
    start_seq(3, 0, 1'b0, 1'b0);
`ifdef SEQ_TIMEOUT_EN
    wait_seq_done(300, ok);
    total++;
    if (!ok || TIMEOUT !== 1'b1 || FAIL_CNT !== 4'd1 || RUNS_DONE !== 4'd1 || ERROR_STICKY !== 1'b1) begin
      bad++; $display("FAIL timeout_fire got=ok%0b to=%0b fail=%0d runs=%0d want=ok1 1/1/1", ok, TIMEOUT, FAIL_CNT, RUNS_DONE);
    end
    // WAIT starts one edge after the init rise; 64 WAIT cycles later SEQ_DONE appears
    total++;
    if (cyc - rise_cyc !== 65) begin bad++; $display("FAIL timeout_cycle got=%0d want=65", cyc - rise_cyc); end
`else
    ok = 1'b1;
    repeat (200) @(negedge ACLK);
    total++;
    if (BUSY !== 1'b1 || TIMEOUT !== 1'b0 || SEQ_DONE !== 1'b0) begin
      bad++; $display("FAIL no_timeout got=%0b/%0b want=1/0", BUSY, TIMEOUT);
    end
`endif
    $display("timeout: ok=%0b busy=%0b timeout=%0b fail=%0d", ok, BUSY, TIMEOUT, FAIL_CNT);
    never_done = 1'b0;
    ARESET = 1'b1;
    @(negedge ACLK);
    ARESET = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stop_on_err();
    test_stale_done();
    test_abort_wait();
    test_abort_gap();
    test_saturate();
    test_async_reset();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
